// File: rtl/car_alarm_pkg.sv
// Shared definitions for the car alarm switch front end: switch bit map,
// channel count and the per-channel debounce state encoding.
package car_alarm_pkg;

    localparam int SW_DRIVER    = 0;
    localparam int SW_PASSENGER = 1;
    localparam int SW_IGNITION  = 2;
    localparam int SW_HIDDEN    = 3;
    localparam int SW_BRAKE     = 4;
    localparam int NUM_SW       = 5;

    typedef enum logic {
        CH_STABLE   = 1'b0,
        CH_SETTLING = 1'b1
    } ch_state_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] value);
        return (value == 3'd7) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: synchronizer, STABLE/SETTLING debounce FSM with
// registered edge pulses, and a sticky chatter detector fed by aborted settles.
module switch_debounce_ch
    import car_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int CHATTER_LIMIT   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic fault_clear,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic fault
);

    localparam logic [3:0] SETTLE_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] BOUNCE_LIMIT = 3'(CHATTER_LIMIT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    ch_state_t              state;
    logic [3:0]             settle_cnt;
    logic [2:0]             bounce_cnt;
    logic [2:0]             bounce_inc;
    logic                   differs;
    logic                   abort;
    logic                   accept;
    logic                   set_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        differs    = synced ^ clean;
        abort      = (state == CH_SETTLING) && !differs;
        accept     = (state == CH_SETTLING) && differs && (settle_cnt == SETTLE_LAST);
        bounce_inc = sat_inc3(bounce_cnt);
        set_fault  = abort && (bounce_inc >= BOUNCE_LIMIT);
    end

    // Pulses default low every cycle so each edge pulse lasts exactly one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CH_STABLE;
            settle_cnt <= '0;
            clean      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                CH_STABLE: begin
                    if (differs) begin
                        state      <= CH_SETTLING;
                        settle_cnt <= 4'd1;
                    end
                end
                CH_SETTLING: begin
                    if (!differs) begin
                        state      <= CH_STABLE;
                        settle_cnt <= '0;
                    end else if (accept) begin
                        state      <= CH_STABLE;
                        settle_cnt <= '0;
                        clean      <= ~clean;
                        rise       <= ~clean;
                        fall       <= clean;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= CH_STABLE;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    // fault_clear always zeroes the bounce count, but a coincident set keeps the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bounce_cnt <= '0;
            fault      <= 1'b0;
        end else begin
            if (fault_clear || accept) begin
                bounce_cnt <= '0;
            end else if (abort) begin
                bounce_cnt <= bounce_inc;
            end
            if (set_fault) begin
                fault <= 1'b1;
            end else if (fault_clear) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/car_switch_conditioner.sv
// Conditions the five raw car switches into clean levels, edge pulses and
// chatter flags using one independent debounce channel per switch.
module car_switch_conditioner
    import car_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int CHATTER_LIMIT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              fault_clear,
    output logic [NUM_SW-1:0] sw_clean,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic [NUM_SW-1:0] chatter_fault
);

    for (genvar ch = 0; ch < NUM_SW; ch++) begin : g_ch
        switch_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .CHATTER_LIMIT   (CHATTER_LIMIT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .raw         (sw_raw[ch]),
            .fault_clear (fault_clear),
            .clean       (sw_clean[ch]),
            .rise        (sw_rise[ch]),
            .fall        (sw_fall[ch]),
            .fault       (chatter_fault[ch])
        );
    end

endmodule
